// File: rtl/relm_adc_seq.sv
// rtl/relm_adc_seq.sv - relm push/pop sequencer for an 8-channel 12-bit serial ADC
//
// One request on the push port runs a two-frame SPI transaction against an
// ADC128S022-class converter. Frame 1 loads the channel address into the
// ADC's mux. Frame 2 returns that channel's sample. The tagged sample is then
// held in a single-entry result register until it is popped.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   cmd_d          push port: [WD] strobe, [2:0] channel
//   cmd_retry      1 = push not accepted this cycle
//   res_d          pop port request: [WD] strobe
//   res_q          pop data: [WD] retry, [14:12] channel, [11:0] sample
//   adc_cs_n_out   ADC chip select, active low
//   adc_saddr_out  ADC address line (DIN)
//   adc_sdat_in    ADC data line (DOUT), asynchronous to clk
//   adc_sclk_out   ADC serial clock, idles high
module relm_adc_seq #(
  parameter int WD  = 32,
  parameter int DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [WD:0] cmd_d,
  output logic        cmd_retry,
  input  logic [WD:0] res_d,
  output logic [WD:0] res_q,
  output logic        adc_cs_n_out,
  output logic        adc_saddr_out,
  input  logic        adc_sdat_in,
  output logic        adc_sclk_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_LOW   = 3'd2,
    S_HIGH  = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
  localparam logic [4:0] BIT_LAST = 5'd31;
  // Frame 2, frame bit 4: first bit carrying sample data (DB11).
  localparam logic [4:0] BIT_CAP0 = 5'd20;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_div_cnt, w_div_nxt;
  logic [4:0]  r_bit, w_bit_nxt;
  logic [2:0]  r_ch;
  logic [11:0] r_sample;
  logic [1:0]  r_sync;
  logic        r_valid;
  logic        r_cs_n, r_sclk, r_saddr;
  logic [WD:0] r_res_q;

  logic       w_div_last, w_accept, w_capture, w_done, w_pop;
  logic       w_cs_n_nxt, w_sclk_nxt, w_saddr_nxt;
  logic [3:0] w_k_nxt;
  logic       w_unused;

  assign w_unused   = ^{cmd_d[WD-1:3], res_d[WD-1:0]};
  assign cmd_retry  = (r_state != S_IDLE) || r_valid;
  assign w_div_last = (r_div_cnt == DIV_LAST);
  // res_q trails r_valid by one cycle. A pop counts only once the data is
  // actually visible on res_q, so a pop can never discard an unseen result.
  assign w_pop      = res_d[WD] && r_valid && !r_res_q[WD];

  assign res_q         = r_res_q;
  assign adc_cs_n_out  = r_cs_n;
  assign adc_sclk_out  = r_sclk;
  assign adc_saddr_out = r_saddr;

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = 8'd0;
    w_bit_nxt   = r_bit;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_done      = 1'b0;

    if (r_state != S_IDLE) begin
      w_div_nxt = w_div_last ? 8'd0 : r_div_cnt + 8'd1;
    end

    case (r_state)
      S_IDLE: begin
        if (cmd_d[WD] && !r_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
          w_bit_nxt   = 5'd0;
        end
      end
      S_SETUP: if (w_div_last) w_state_nxt = S_LOW;
      S_LOW:   if (w_div_last) w_state_nxt = S_HIGH;
      S_HIGH: begin
        if (w_div_last) begin
          w_capture = (r_bit >= BIT_CAP0);
          if (r_bit == BIT_LAST) begin
            w_state_nxt = S_HOLD;
            w_bit_nxt   = 5'd0;
          end else begin
            w_state_nxt = S_LOW;
            w_bit_nxt   = r_bit + 5'd1;
          end
        end
      end
      S_HOLD:  if (w_div_last) w_state_nxt = S_GAP;
      S_GAP: begin
        if (w_div_last) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Pins are registered from the next state so they switch on the same
    // edge as the state. The address bit therefore appears with the falling
    // SCLK and holds through the rising edge where the ADC samples it.
    w_k_nxt     = w_bit_nxt[3:0];
    w_cs_n_nxt  = (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
    w_sclk_nxt  = (w_state_nxt != S_LOW);
    w_saddr_nxt = 1'b0;
    if ((w_state_nxt == S_LOW) || (w_state_nxt == S_HIGH)) begin
      case (w_k_nxt)
        4'd2:    w_saddr_nxt = r_ch[2];
        4'd3:    w_saddr_nxt = r_ch[1];
        4'd4:    w_saddr_nxt = r_ch[0];
        default: w_saddr_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_div_cnt <= 8'd0;
      r_bit     <= 5'd0;
      r_ch      <= 3'd0;
      r_sample  <= 12'd0;
      r_sync    <= 2'd0;
      r_valid   <= 1'b0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b1;
      r_saddr   <= 1'b0;
      r_res_q   <= {1'b1, {WD{1'b0}}};
    end else begin
      r_state   <= w_state_nxt;
      r_div_cnt <= w_div_nxt;
      r_bit     <= w_bit_nxt;
      r_sync    <= {r_sync[0], adc_sdat_in};
      r_cs_n    <= w_cs_n_nxt;
      r_sclk    <= w_sclk_nxt;
      r_saddr   <= w_saddr_nxt;
      if (w_accept) r_ch <= cmd_d[2:0];
      if (w_capture) r_sample <= {r_sample[10:0], r_sync[1]};
      if (w_done) begin
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
      r_res_q <= r_valid ? {1'b0, {(WD-15){1'b0}}, r_ch, r_sample}
                         : {1'b1, {WD{1'b0}}};
    end
  end

endmodule
